// File: rtl/fir_pkg.sv
// Shared FIR delay-line parameters and helpers.
// Default sample width/depth and the fill-count width used on ports.
package fir_pkg;

  localparam int FIR_DATA_W = 10;
  localparam int FIR_TAPS   = 8;

  function automatic int fill_w(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/fir_tap_reg.sv
// One delay-line stage: loads d_i when enabled, clears synchronously.
// Clear has priority over load.
module fir_tap_reg
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_DATA_W
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/fir_tap_delay_line.sv
// Qualified-shift FIR sample delay line with flush, fill tracking
// and a registered window-valid strobe for the MAC stage.
module fir_tap_delay_line
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_DATA_W,
  parameter int TAPS  = FIR_TAPS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      flush,
  output logic [WIDTH*TAPS-1:0]     taps_out,
  output logic [fill_w(TAPS)-1:0]   fill_count,
  output logic                      win_full,
  output logic                      out_valid
);

  localparam int FW = fill_w(TAPS);
  localparam logic [FW-1:0] FULL = FW'(TAPS);
  localparam logic [FW-1:0] ONE  = FW'(1);

  logic [WIDTH-1:0] tap_q [TAPS];

  // Head stage: flush+valid reloads with the new sample instead of clearing.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    if (k == 0) begin : g_head
      fir_tap_reg #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .clr_i (rst | (flush & ~in_valid)),
        .en_i  (in_valid),
        .d_i   (in_data),
        .q_o   (tap_q[k])
      );
    end else begin : g_body
      fir_tap_reg #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .clr_i (rst | flush),
        .en_i  (in_valid),
        .d_i   (tap_q[k-1]),
        .q_o   (tap_q[k])
      );
    end
    assign taps_out[k*WIDTH +: WIDTH] = tap_q[k];
  end

  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_d;
  logic          ov_q;
  logic          ov_d;

  always_comb begin
    fill_d = fill_q;
    ov_d   = 1'b0;
    if (flush) begin
      fill_d = in_valid ? ONE : '0;
      ov_d   = in_valid && (FULL == ONE);
    end else if (in_valid) begin
      fill_d = (fill_q == FULL) ? FULL : fill_q + ONE;
      ov_d   = (fill_d == FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
      ov_q   <= 1'b0;
    end else begin
      fill_q <= fill_d;
      ov_q   <= ov_d;
    end
  end

  assign fill_count = fill_q;
  assign win_full   = (fill_q == FULL);
  assign out_valid  = ov_q;

endmodule

// File: tb/tb_fir_tap_delay_line.sv
// Directed plus random checks of the FIR delay line against an array model
// for WIDTH=10/TAPS=4 and WIDTH=16/TAPS=2.
module tb_fir_tap_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=10, TAPS=4
  logic        ra, va, fa;
  logic [9:0]  da;
  logic [39:0] toa;
  logic [2:0]  fca;
  logic        wfa, ova;

  // Instance B: WIDTH=16, TAPS=2
  logic        rb, vb, fb;
  logic [15:0] db;
  logic [31:0] tob;
  logic [1:0]  fcb;
  logic        wfb, ovb;

  fir_tap_delay_line #(.WIDTH(10), .TAPS(4)) dut_a (
    .clk        (clk),
    .rst        (ra),
    .in_valid   (va),
    .in_data    (da),
    .flush      (fa),
    .taps_out   (toa),
    .fill_count (fca),
    .win_full   (wfa),
    .out_valid  (ova)
  );

  fir_tap_delay_line #(.WIDTH(16), .TAPS(2)) dut_b (
    .clk        (clk),
    .rst        (rb),
    .in_valid   (vb),
    .in_data    (db),
    .flush      (fb),
    .taps_out   (tob),
    .fill_count (fcb),
    .win_full   (wfb),
    .out_valid  (ovb)
  );

  // Reference state: the window as an array, newest sample at index 0
  logic [9:0]  ma [4];
  int          mfa;
  bit          mova;
  int          ov_seen_a;
  logic [15:0] mb [2];
  int          mfb;
  bit          movb;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step_a(input string tag, input bit r, input bit v,
                        input bit f, input logic [9:0] d);
    logic [39:0] e;
    ra = r; va = v; fa = f; da = d;
    if (r) begin
      foreach (ma[k]) ma[k] = '0;
      mfa = 0; mova = 0;
    end else if (f) begin
      foreach (ma[k]) ma[k] = '0;
      if (v) ma[0] = d;
      mfa = v ? 1 : 0;
      mova = 0;
    end else if (v) begin
      for (int k = 3; k > 0; k--) ma[k] = ma[k-1];
      ma[0] = d;
      mfa = (mfa < 4) ? mfa + 1 : 4;
      mova = (mfa == 4);
    end else begin
      mova = 0;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) e[k*10 +: 10] = ma[k];
    chk({tag, ".taps"}, 64'(toa), 64'(e));
    chk({tag, ".fill"}, 64'(fca), 64'(mfa));
    chk({tag, ".full"}, 64'(wfa), 64'(mfa == 4));
    chk({tag, ".ov"},   64'(ova), 64'(mova));
    if (ova) ov_seen_a++;
  endtask

  task automatic step_b(input string tag, input bit r, input bit v,
                        input bit f, input logic [15:0] d);
    logic [31:0] e;
    rb = r; vb = v; fb = f; db = d;
    if (r) begin
      mb[0] = '0; mb[1] = '0;
      mfb = 0; movb = 0;
    end else if (f) begin
      mb[0] = v ? d : '0; mb[1] = '0;
      mfb = v ? 1 : 0;
      movb = 0;
    end else if (v) begin
      mb[1] = mb[0];
      mb[0] = d;
      mfb = (mfb < 2) ? mfb + 1 : 2;
      movb = (mfb == 2);
    end else begin
      movb = 0;
    end
    @(posedge clk);
    #1;
    e = {mb[1], mb[0]};
    chk({tag, ".taps"}, 64'(tob), 64'(e));
    chk({tag, ".fill"}, 64'(fcb), 64'(mfb));
    chk({tag, ".full"}, 64'(wfb), 64'(mfb == 2));
    chk({tag, ".ov"},   64'(ovb), 64'(movb));
  endtask

  initial begin
    ra = 1'b1; va = 1'b0; fa = 1'b0; da = '0;
    rb = 1'b1; vb = 1'b0; fb = 1'b0; db = '0;
    mfa = 0; mova = 0; ov_seen_a = 0;
    mfb = 0; movb = 0;
    foreach (ma[k]) ma[k] = '0;
    mb[0] = '0; mb[1] = '0;

    // Reset overrides valid input
    step_a("rst", 1, 1, 0, 10'h3FF);
    step_a("rst", 1, 1, 0, 10'h3FF);
    chk("rst.zero", 64'(toa), 64'(0));

    // Fill window
    for (int i = 1; i <= 4; i++) step_a("fill", 0, 1, 0, 10'(i));
    chk("fill.win", 64'(toa), 64'({10'd1, 10'd2, 10'd3, 10'd4}));

    // Gapped input
    step_a("gap", 0, 1, 0, 10'd5);
    for (int i = 0; i < 3; i++) step_a("gap.idle", 0, 0, 0, 10'h155);
    chk("gap.hold", 64'(toa), 64'({10'd2, 10'd3, 10'd4, 10'd5}));
    step_a("gap", 0, 1, 0, 10'd6);
    chk("gap.win", 64'(toa), 64'({10'd3, 10'd4, 10'd5, 10'd6}));

    // Flush together with a sample
    step_a("fv", 0, 1, 1, 10'h2AA);
    chk("fv.win", 64'(toa), 64'({30'd0, 10'h2AA}));
    chk("fv.fill", 64'(fca), 64'(1));
    for (int i = 0; i < 3; i++) step_a("fv.refill", 0, 1, 0, 10'($urandom));
    chk("fv.ov", 64'(ova), 64'(1));

    // Flush alone
    step_a("fl", 0, 0, 1, 10'h111);

    // Saturation
    ov_seen_a = 0;
    for (int i = 0; i < 20; i++) step_a("sat", 0, 1, 0, 10'($urandom));
    chk("sat.fill", 64'(fca), 64'(4));
    chk("sat.ovcnt", 64'(ov_seen_a), 64'(17));

    // Reset mid-fill
    step_a("mid", 0, 0, 1, 10'h0);
    step_a("mid", 0, 1, 0, 10'h0AB);
    step_a("mid", 0, 1, 0, 10'h0CD);
    step_a("mid.rst", 1, 1, 0, 10'h3FF);
    ov_seen_a = 0;
    for (int i = 0; i < 4; i++) step_a("mid.refill", 0, 1, 0, 10'($urandom));
    chk("mid.ovcnt", 64'(ov_seen_a), 64'(1));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step_a("rnd", $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 19) == 0, 10'($urandom));
    end

    // Second configuration: wide samples, two taps
    step_b("b.rst", 1, 1, 0, 16'hFFFF);
    step_b("b.s", 0, 1, 0, 16'h8000);
    step_b("b.rst", 1, 1, 0, 16'h1234);
    step_b("b.s", 0, 1, 0, 16'h8000);
    step_b("b.s", 0, 1, 0, 16'h7FFF);
    chk("b.win", 64'(tob), 64'({16'h8000, 16'h7FFF}));
    step_b("b.s", 0, 1, 1, 16'h8001);
    for (int i = 0; i < 150; i++) begin
      step_b("b.rnd", $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 19) == 0, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
